// File: rtl/nubus_bridge_pkg.sv
// Shared types for the NuBus processor-side bridge.
// Contents:
//   bridge_state_t  - request sequencer states (IDLE, ISSUE, WAIT, RESP)
//   ST_*            - NuBus ACK status encodings returned by the core master
//   req_entry_t     - one buffered processor request (addr, wdata, wstrb, lock)
//   is_read()       - a request with all byte strobes clear is a read
package nubus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_RETRY = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        lock;
    } req_entry_t;

    function automatic logic is_read(input req_entry_t e);
        return (e.wstrb == 4'b0000);
    endfunction

endpackage

// File: rtl/nubus_req_fifo.sv
// Request FIFO between the processor port and the NuBus sequencer.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   push, din   - write one entry (ignored when full)
//   pop         - retire the head entry (ignored when empty)
//   head        - current head entry
//   full, empty - occupancy flags
//   single      - exactly one entry held (the head is the last one)
module nubus_req_fifo
    import nubus_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  req_entry_t din,
    input  logic       pop,
    output req_entry_t head,
    output logic       full,
    output logic       empty,
    output logic       single
);

    localparam int AW = $clog2(DEPTH);

    req_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign single  = (count == (AW+1)'(1));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/nubus_cpu_bridge.sv
// Upstream stage of the NuBus master port. Buffers processor requests in a
// small FIFO and presents them one at a time to the NuBus core master,
// re-issuing on try-again status. Writes are posted (acknowledged on
// acceptance); reads block until the NuBus transfer completes.
// Optional build macro: NUBUS_TIMEOUT_EN adds a WAIT-state watchdog that
// forces a timeout completion after TIMEOUT_CYCLES cycles without mst_ack.
// Ports:
//   nub_clk, nub_reset           - clock, synchronous active-high reset
//   p_valid/p_addr/p_wdata/p_wstrb/p_lock - processor request (wstrb 0 = read)
//   p_ready/p_rdata/p_err        - completion pulse, read data, read error
//   wr_err, err_clr              - sticky posted-write error and its clear
//   mst_rqst/mst_addr/mst_wdata/mst_wstrb/mst_lock - head request to core master
//   mst_ack/mst_status/mst_rdata - transfer completion from core master
module nubus_cpu_bridge
    import nubus_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_RETRY      = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        nub_clk,
    input  logic        nub_reset,
    input  logic        p_valid,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic [3:0]  p_wstrb,
    input  logic        p_lock,
    output logic        p_ready,
    output logic [31:0] p_rdata,
    output logic        p_err,
    output logic        wr_err,
    input  logic        err_clr,
    output logic        mst_rqst,
    output logic [31:0] mst_addr,
    output logic [31:0] mst_wdata,
    output logic [3:0]  mst_wstrb,
    output logic        mst_lock,
    input  logic        mst_ack,
    input  logic [1:0]  mst_status,
    input  logic [31:0] mst_rdata
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    bridge_state_t state;
    bridge_state_t state_next;
    req_entry_t    head;
    req_entry_t    new_entry;
    logic          full;
    logic          empty;
    logic          single;
    logic          wr_accept;
    logic          rd_accept;
    logic          push;
    logic          pop;
    logic          read_out;
    logic [RW-1:0] retry;
    logic [1:0]    resp_status;
    logic          wait_done;
    logic [1:0]    done_status;
    logic [31:0]   done_rdata;
    logic          retry_now;

    // Writes need room; reads need an empty FIFO and no read in flight.
    // ~p_ready keeps a request still held during its own completion pulse
    // from being taken twice.
    assign wr_accept = p_valid & (|p_wstrb) & ~full & ~p_ready;
    assign rd_accept = p_valid & ~(|p_wstrb) & empty & ~read_out & ~p_ready;
    assign push      = wr_accept | rd_accept;
    assign pop       = (state == RESP);
    assign new_entry = '{addr: p_addr, wdata: p_wdata, wstrb: p_wstrb, lock: p_lock};

    nubus_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (nub_clk),
        .reset  (nub_reset),
        .push   (push),
        .din    (new_entry),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .single (single)
    );

`ifdef NUBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          tmo_hit;

    // Counts WAIT cycles without an ACK; cleared on the way into WAIT.
    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !mst_ack && !tmo_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A real ACK in the same cycle as the watchdog firing takes precedence.
    assign tmo_hit     = (wait_cnt == TW'(TIMEOUT_CYCLES));
    assign wait_done   = mst_ack | tmo_hit;
    assign done_status = mst_ack ? mst_status : ST_TMO;
    assign done_rdata  = mst_ack ? mst_rdata : '0;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wait_done   = mst_ack;
    assign done_status = mst_status;
    assign done_rdata  = mst_rdata;
`endif

    // Only a genuine try-again ACK with retries left sends the entry back to ISSUE.
    assign retry_now = mst_ack & (mst_status == ST_RETRY) & (retry < RW'(MAX_RETRY));

    always_ff @(posedge nub_clk) begin
        if (nub_reset) state <= IDLE;
        else           state <= state_next;
    end

    // IDLE and RESP also look at a same-cycle push so a request arriving on
    // an idle bridge reaches ISSUE straight after its acceptance cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty || push) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_done) state_next = retry_now ? ISSUE : RESP;
            RESP:    state_next = (!single || push) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read completion is registered on the final ACK so p_ready/p_rdata/p_err
    // are visible during the RESP cycle, one cycle after mst_ack.
    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            p_ready     <= 1'b0;
            p_rdata     <= '0;
            p_err       <= 1'b0;
            read_out    <= 1'b0;
            retry       <= '0;
            resp_status <= ST_OK;
        end else begin
            p_ready <= wr_accept;
            p_rdata <= '0;
            p_err   <= 1'b0;
            if (rd_accept) read_out <= 1'b1;
            if (state == WAIT && wait_done) begin
                if (retry_now) begin
                    retry <= retry + 1'b1;
                end else begin
                    resp_status <= done_status;
                    if (is_read(head)) begin
                        p_ready <= 1'b1;
                        p_rdata <= done_rdata;
                        p_err   <= (done_status != ST_OK);
                    end
                end
            end
            if (state == RESP) begin
                retry <= '0;
                if (is_read(head)) read_out <= 1'b0;
            end
        end
    end

    // A new write error beats a simultaneous clear.
    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            wr_err <= 1'b0;
        end else if (state == RESP && !is_read(head) && resp_status != ST_OK) begin
            wr_err <= 1'b1;
        end else if (err_clr) begin
            wr_err <= 1'b0;
        end
    end

    // Head fields are shown whenever an entry exists, so mst_lock stays up
    // through the idle cycle between try-again re-issues.
    assign mst_rqst  = (state == WAIT);
    assign mst_addr  = empty ? '0 : head.addr;
    assign mst_wdata = empty ? '0 : head.wdata;
    assign mst_wstrb = empty ? '0 : head.wstrb;
    assign mst_lock  = ~empty & head.lock;

endmodule

// File: tb/tb_nubus_cpu_bridge.sv
// Self-checking bench for nubus_cpu_bridge: directed processor/NuBus
// sequences, a transaction-level reference model, and per-cycle comparison.
module tb_nubus_cpu_bridge;
    import nubus_bridge_pkg::*;

    localparam int FIFO_DEPTH     = 4;
    localparam int MAX_RETRY      = 7;
    localparam int TIMEOUT_CYCLES = 16;

    logic        nub_clk = 1'b0;
    logic        nub_reset;
    logic        p_valid;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    logic        p_lock;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic        p_err;
    logic        wr_err;
    logic        err_clr;
    logic        mst_rqst;
    logic [31:0] mst_addr;
    logic [31:0] mst_wdata;
    logic [3:0]  mst_wstrb;
    logic        mst_lock;
    logic        mst_ack;
    logic [1:0]  mst_status;
    logic [31:0] mst_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;
    int issues       = 0;
    bit rq_prev      = 1'b0;

    always #5 nub_clk = ~nub_clk;

    nubus_cpu_bridge #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .MAX_RETRY      (MAX_RETRY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .nub_clk    (nub_clk),
        .nub_reset  (nub_reset),
        .p_valid    (p_valid),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_wstrb    (p_wstrb),
        .p_lock     (p_lock),
        .p_ready    (p_ready),
        .p_rdata    (p_rdata),
        .p_err      (p_err),
        .wr_err     (wr_err),
        .err_clr    (err_clr),
        .mst_rqst   (mst_rqst),
        .mst_addr   (mst_addr),
        .mst_wdata  (mst_wdata),
        .mst_wstrb  (mst_wstrb),
        .mst_lock   (mst_lock),
        .mst_ack    (mst_ack),
        .mst_status (mst_status),
        .mst_rdata  (mst_rdata)
    );

    // Reference model: a queue of outstanding requests, retry bookkeeping for
    // the head, and the outputs each rule says must appear after this edge.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        lock;
    } m_entry_t;

    m_entry_t    m_q[$];
    int          m_retry    = 0;
    bit          m_resp     = 1'b0;
    logic [1:0]  m_status   = 2'b00;
    bit          m_read_out = 1'b0;
    bit          exp_ready  = 1'b0;
    logic [31:0] exp_rdata  = '0;
    bit          exp_err    = 1'b0;
    bit          exp_wr_err = 1'b0;

    always @(posedge nub_clk) begin : model
        bit          pop_now;
        bit          nr;
        bit          ne;
        bit          set_err;
        logic [31:0] nd;
        int          pre_size;
        m_entry_t    e;
        if (nub_reset) begin
            m_q.delete();
            m_retry    = 0;
            m_resp     = 1'b0;
            m_read_out = 1'b0;
            exp_ready  = 1'b0;
            exp_rdata  = '0;
            exp_err    = 1'b0;
            exp_wr_err = 1'b0;
        end else begin
            nr = 1'b0; ne = 1'b0; nd = '0; set_err = 1'b0;
            pre_size = m_q.size();
            pop_now  = m_resp;
            m_resp   = 1'b0;
            // A final ACK one cycle ago retires the head now.
            if (pop_now) begin
                e = m_q.pop_front();
                if (e.wstrb != 4'b0000 && m_status != 2'b00) set_err = 1'b1;
                if (e.wstrb == 4'b0000) m_read_out = 1'b0;
                m_retry = 0;
            end else if (mst_ack && pre_size > 0) begin
                if (mst_status == 2'b11 && m_retry < MAX_RETRY) begin
                    m_retry++;
                end else begin
                    m_resp   = 1'b1;
                    m_status = mst_status;
                    if (m_q[0].wstrb == 4'b0000) begin
                        nr = 1'b1;
                        nd = mst_rdata;
                        ne = (mst_status != 2'b00);
                    end
                end
            end
            // Acceptance is judged on occupancy before this edge's retirement.
            if (p_valid && p_wstrb != 4'b0000 && pre_size < FIFO_DEPTH && !exp_ready) begin
                m_q.push_back('{p_addr, p_wdata, p_wstrb, p_lock});
                nr = 1'b1;
            end else if (p_valid && p_wstrb == 4'b0000 && pre_size == 0 && !m_read_out && !exp_ready) begin
                m_q.push_back('{p_addr, p_wdata, p_wstrb, p_lock});
                m_read_out = 1'b1;
            end
            exp_ready  = nr;
            exp_rdata  = nd;
            exp_err    = ne;
            exp_wr_err = set_err ? 1'b1 : (err_clr ? 1'b0 : exp_wr_err);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge nub_clk) begin
        if (chk_en) begin
            checkOutput("p_ready", {31'd0, p_ready}, {31'd0, exp_ready});
            if (exp_ready) begin
                checkOutput("p_rdata", p_rdata, exp_rdata);
                checkOutput("p_err", {31'd0, p_err}, {31'd0, exp_err});
            end
            checkOutput("wr_err", {31'd0, wr_err}, {31'd0, exp_wr_err});
            if (m_q.size() == 0) begin
                checkOutput("mst_rqst_empty", {31'd0, mst_rqst}, 32'd0);
            end else if (mst_rqst) begin
                checkOutput("mst_addr", mst_addr, m_q[0].addr);
                checkOutput("mst_wdata", mst_wdata, m_q[0].wdata);
                checkOutput("mst_wstrb", {28'd0, mst_wstrb}, {28'd0, m_q[0].wstrb});
                checkOutput("mst_lock", {31'd0, mst_lock}, {31'd0, m_q[0].lock});
            end
        end
    end

    // Counts distinct NuBus issues (rising edges of mst_rqst).
    always @(posedge nub_clk) begin
        if (mst_rqst && !rq_prev) issues++;
        rq_prev = mst_rqst;
    end

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic l);
        p_valid = v; p_addr = a; p_wdata = d; p_wstrb = s; p_lock = l;
    endtask

    task automatic waitReady(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge nub_clk);
            if (p_ready) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic waitRqst(input int max, output int cyc);
        cyc = -1;
        for (int i = 0; i <= max; i++) begin
            if (mst_rqst) begin
                cyc = i;
                break;
            end
            @(negedge nub_clk);
        end
    endtask

    task automatic ackOnce(input logic [1:0] st, input logic [31:0] rd);
        mst_ack = 1'b1; mst_status = st; mst_rdata = rd;
        @(negedge nub_clk);
        mst_ack = 1'b0; mst_status = 2'b00; mst_rdata = '0;
    endtask

    initial begin : watchdog
        #200000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : stimulus
        int cyc;
        int base;
        int acc;
        nub_reset = 1'b1; err_clr = 1'b0;
        mst_ack = 1'b0; mst_status = 2'b00; mst_rdata = '0;
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        repeat (3) @(negedge nub_clk);
        chk_en = 1'b1;
        checkOutput("reset_p_ready", {31'd0, p_ready}, 32'd0);
        checkOutput("reset_mst_rqst", {31'd0, mst_rqst}, 32'd0);
        checkOutput("reset_mst_addr", mst_addr, 32'd0);
        checkOutput("reset_wr_err", {31'd0, wr_err}, 32'd0);
        nub_reset = 1'b0;
        repeat (2) @(negedge nub_clk);

        $display("[TB] posted write");
        applyStimulus(1'b1, 32'hF300_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        waitReady(4, cyc);
        checkOutput("t1_ready_latency", cyc, 32'd1);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        waitRqst(8, cyc);
        checkOutput("t1_rqst_latency", cyc, 32'd1);
        checkOutput("t1_mst_addr", mst_addr, 32'hF300_0010);
        checkOutput("t1_mst_wdata", mst_wdata, 32'hDEAD_BEEF);
        checkOutput("t1_mst_wstrb", {28'd0, mst_wstrb}, 32'hF);
        ackOnce(ST_OK, '0);
        repeat (3) @(negedge nub_clk);
        checkOutput("t1_wr_err", {31'd0, wr_err}, 32'd0);

        $display("[TB] read ok");
        applyStimulus(1'b1, 32'hF300_0020, '0, 4'h0, 1'b0);
        waitRqst(8, cyc);
        checkOutput("t2_rqst_latency", cyc, 32'd2);
        checkOutput("t2_mst_addr", mst_addr, 32'hF300_0020);
        ackOnce(ST_OK, 32'h1234_5678);
        checkOutput("t2_p_ready", {31'd0, p_ready}, 32'd1);
        checkOutput("t2_p_rdata", p_rdata, 32'h1234_5678);
        checkOutput("t2_p_err", {31'd0, p_err}, 32'd0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        repeat (3) @(negedge nub_clk);

        $display("[TB] fifo full stall");
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'hF300_0100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF, 1'b0);
            waitReady(4, cyc);
            if (cyc > 0) acc++;
            applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        end
        checkOutput("t3_accepted", acc, 32'd4);
        applyStimulus(1'b1, 32'hF300_0110, 32'hA000_0004, 4'hF, 1'b0);
        waitReady(6, cyc);
        checkOutput("t3_fifth_stalls", cyc, 32'hFFFF_FFFF);
        checkOutput("t3_head_addr", mst_addr, 32'hF300_0100);
        ackOnce(ST_OK, '0);
        waitReady(6, cyc);
        checkOutput("t3_fifth_latency", cyc, 32'd2);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            waitRqst(8, cyc);
            checkOutput("t3_drain_rqst", {31'd0, cyc >= 0}, 32'd1);
            checkOutput("t3_drain_addr", mst_addr, 32'hF300_0104 + 32'(k * 4));
            ackOnce(ST_OK, '0);
        end
        repeat (3) @(negedge nub_clk);
        checkOutput("t3_drained", {31'd0, mst_rqst}, 32'd0);

        $display("[TB] locked read with retries");
        base = issues;
        applyStimulus(1'b1, 32'hF300_0030, '0, 4'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            waitRqst(8, cyc);
            checkOutput("t4_rqst", cyc, (k == 0) ? 32'd2 : 32'd1);
            if (k < 3) begin
                ackOnce(ST_RETRY, '0);
                checkOutput("t4_gap_rqst", {31'd0, mst_rqst}, 32'd0);
                checkOutput("t4_gap_lock", {31'd0, mst_lock}, 32'd1);
            end else begin
                ackOnce(ST_OK, 32'hCAFE_0004);
            end
        end
        checkOutput("t4_p_ready", {31'd0, p_ready}, 32'd1);
        checkOutput("t4_p_rdata", p_rdata, 32'hCAFE_0004);
        checkOutput("t4_p_err", {31'd0, p_err}, 32'd0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        repeat (2) @(negedge nub_clk);
        checkOutput("t4_issues", issues - base, 32'd4);

        $display("[TB] read retries exhausted");
        base = issues;
        applyStimulus(1'b1, 32'hF300_0034, '0, 4'h0, 1'b0);
        for (int k = 0; k < MAX_RETRY + 1; k++) begin
            waitRqst(8, cyc);
            ackOnce(ST_RETRY, 32'h0BAD_0000);
        end
        checkOutput("t4b_p_ready", {31'd0, p_ready}, 32'd1);
        checkOutput("t4b_p_err", {31'd0, p_err}, 32'd1);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        repeat (2) @(negedge nub_clk);
        checkOutput("t4b_issues", issues - base, 32'd8);

        $display("[TB] ack outside wait");
        ackOnce(ST_ERR, 32'h5555_5555);
        repeat (2) @(negedge nub_clk);
        checkOutput("stray_ack_wr_err", {31'd0, wr_err}, 32'd0);
        checkOutput("stray_ack_rqst", {31'd0, mst_rqst}, 32'd0);

        $display("[TB] write error flag");
        applyStimulus(1'b1, 32'hF300_0040, 32'h1111_1111, 4'h3, 1'b0);
        waitReady(4, cyc);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        waitRqst(8, cyc);
        ackOnce(ST_ERR, '0);
        @(negedge nub_clk);
        checkOutput("t5_wr_err_set", {31'd0, wr_err}, 32'd1);
        err_clr = 1'b1;
        @(negedge nub_clk);
        err_clr = 1'b0;
        checkOutput("t5_wr_err_clr", {31'd0, wr_err}, 32'd0);
        applyStimulus(1'b1, 32'hF300_0044, 32'h2222_2222, 4'hC, 1'b0);
        waitReady(4, cyc);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        waitRqst(8, cyc);
        ackOnce(ST_ERR, '0);
        err_clr = 1'b1;
        @(negedge nub_clk);
        err_clr = 1'b0;
        checkOutput("t5_set_beats_clr", {31'd0, wr_err}, 32'd1);

        $display("[TB] reset mid-wait");
        applyStimulus(1'b1, 32'hF300_0050, '0, 4'h0, 1'b0);
        waitRqst(8, cyc);
        checkOutput("t6_rqst_before_reset", {31'd0, mst_rqst}, 32'd1);
        nub_reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        @(negedge nub_clk);
        checkOutput("t6_reset_rqst", {31'd0, mst_rqst}, 32'd0);
        checkOutput("t6_reset_ready", {31'd0, p_ready}, 32'd0);
        checkOutput("t6_reset_addr", mst_addr, 32'd0);
        checkOutput("t6_reset_wr_err", {31'd0, wr_err}, 32'd0);
        nub_reset = 1'b0;
        repeat (4) @(negedge nub_clk);

`ifdef NUBUS_TIMEOUT_EN
        $display("[TB] wait watchdog");
        chk_en = 1'b0;
        applyStimulus(1'b1, 32'hF300_0060, '0, 4'h0, 1'b0);
        waitRqst(8, cyc);
        waitReady(40, cyc);
        checkOutput("t7_timeout_latency", cyc, 32'd17);
        checkOutput("t7_timeout_err", {31'd0, p_err}, 32'd1);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0);
        nub_reset = 1'b1;
        @(negedge nub_clk);
        nub_reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge nub_clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
